// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: ALU control codes, FSM encoding,
// iteration bounds.
package ex_muldiv_unit_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned ITER_LAST    = MULDIV_WIDTH - 1;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-to-muldiv request bundle and its result/status signals.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  import ex_muldiv_unit_pkg::*;

  logic [3:0]       ALU_Control;
  logic             Valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output ALU_Control, Valid, A, B,
    input  Stall, Busy, Done, DivByZero, HI, LO
  );

  modport slave (
    input  ALU_Control, Valid, A, B,
    output Stall, Busy, Done, DivByZero, HI, LO
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Magnitude/accumulator datapath: one shift-add or restoring-divide step per cycle,
// plus combinational sign correction of the final result.
module muldiv_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             op_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             div_zero
);

  logic               sign_a_q, sign_b_q, is_div_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // Two's-complement negation of the most negative value yields 2^(WIDTH-1) as unsigned.
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
    end else if (load) begin
      sign_a_q <= a[WIDTH-1];
      sign_b_q <= b[WIDTH-1];
      is_div_q <= op_div;
      mag_a_q  <= abs_a;
      mag_b_q  <= abs_b;
      // Low half seeds the multiplier (mult) or the dividend (div).
      acc_q    <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
    end else if (step) begin
      acc_q <= acc_d;
    end
  end

  logic [WIDTH:0] mul_sum, rem_sh, diff;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, mag_b_q};
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (diff[WIDTH]) begin
        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign div_zero = is_div_q & (mag_b_q == '0);
  assign prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    {hi_res, lo_res} = prod;
    if (div_zero) begin
      hi_res = sign_a_q ? -mag_a_q : mag_a_q;
      lo_res = '1;
    end else if (is_div_q) begin
      hi_res = sign_a_q ? -rem : rem;
      lo_res = (sign_a_q ^ sign_b_q) ? -quo : quo;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative signed mult/div for the EX stage: request accept/stall, FSM, iteration counter
// and the architectural HI/LO registers.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input logic            Clk,
  input logic            Reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] IterLast = CntW'(WIDTH - 1);

  muldiv_state_e    state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             is_mult, is_div, request, accept, step;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic             div_zero;

  assign is_mult = bus.ALU_Control == ALU_MULT;
  assign is_div  = bus.ALU_Control == ALU_DIV;
  assign request = bus.Valid & (is_mult | is_div);
  assign accept  = request & (state_q == StIdle);
  assign step    = (state_q == StMul) | (state_q == StDiv);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_div)             state_d = StMul;
          else if (bus.B == '0)    state_d = StFix;
          else                     state_d = StDiv;
        end
      end
      StMul, StDiv: if (cnt_q == IterLast) state_d = StFix;
      StFix:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == StFix;
      if (accept) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
        dbz_q  <= 1'b0;
      end else begin
        if (step) cnt_q <= cnt_q + 1'b1;
        if (state_q == StFix) begin
          busy_q <= 1'b0;
          dbz_q  <= div_zero;
          hi_q   <= hi_res;
          lo_q   <= lo_res;
        end
      end
    end
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (Clk),
    .reset    (Reset),
    .load     (accept),
    .op_div   (is_div),
    .step     (step),
    .a        (bus.A),
    .b        (bus.B),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  assign bus.Stall     = request & busy_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: signed mult/div results, timing, stall, reset abort.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one request for a single edge, then count cycles until Busy falls.
  // Returns positioned at the negedge right after the final (FIX) edge.
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    bus.Valid       = 1'b1;
    bus.ALU_Control = code;
    bus.A           = a;
    bus.B           = b;
    @(negedge clk);
    bus.Valid       = 1'b0;
    bus.ALU_Control = ALU_ADD;
    busy_cycles     = 0;
    for (int i = 0; i < 100 && bus.Busy; i++) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  int                 cyc;
  int                 bad;
  logic signed [63:0] ref_prod;

  initial begin
    bus.Valid       = 1'b0;
    bus.ALU_Control = ALU_ADD;
    bus.A           = '0;
    bus.B           = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_busy", 64'(bus.Busy), 64'd0);
    check_eq("rst_done", 64'(bus.Done), 64'd0);
    check_eq("rst_dbz", 64'(bus.DivByZero), 64'd0);
    check_eq("rst_hi", 64'(bus.HI), 64'd0);
    check_eq("rst_lo", 64'(bus.LO), 64'd0);

    // 7 * -3 = -21
    run_op(ALU_MULT, 32'd7, 32'hFFFF_FFFD, cyc);
    check_eq("mul1_busy_cycles", 64'(cyc), 64'd33);
    check_eq("mul1_done", 64'(bus.Done), 64'd1);
    check_eq("mul1_hi", 64'(bus.HI), 64'hFFFF_FFFF);
    check_eq("mul1_lo", 64'(bus.LO), 64'hFFFF_FFEB);
    check_eq("mul1_dbz", 64'(bus.DivByZero), 64'd0);
    @(negedge clk);
    check_eq("mul1_done_pulse", 64'(bus.Done), 64'd0);

    // -7 / 2 = -3 rem -1
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    check_eq("div1_busy_cycles", 64'(cyc), 64'd33);
    check_eq("div1_done", 64'(bus.Done), 64'd1);
    check_eq("div1_lo", 64'(bus.LO), 64'hFFFF_FFFD);
    check_eq("div1_hi", 64'(bus.HI), 64'hFFFF_FFFF);

    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check_eq("div_ovf_lo", 64'(bus.LO), 64'h8000_0000);
    check_eq("div_ovf_hi", 64'(bus.HI), 64'd0);

    // Divide by zero: single busy cycle, HI keeps the dividend
    run_op(ALU_DIV, 32'd5, 32'd0, cyc);
    check_eq("dbz_busy_cycles", 64'(cyc), 64'd1);
    check_eq("dbz_done", 64'(bus.Done), 64'd1);
    check_eq("dbz_lo", 64'(bus.LO), 64'hFFFF_FFFF);
    check_eq("dbz_hi", 64'(bus.HI), 64'd5);
    check_eq("dbz_flag", 64'(bus.DivByZero), 64'd1);
    run_op(ALU_MULT, 32'd2, 32'd3, cyc);
    check_eq("dbz_clear_flag", 64'(bus.DivByZero), 64'd0);
    check_eq("dbz_clear_lo", 64'(bus.LO), 64'd6);

    // Mult requested 10 cycles into a div: 100 / 7 = 14 rem 2
    bus.Valid = 1'b1; bus.ALU_Control = ALU_DIV; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.Valid = 1'b0; bus.ALU_Control = ALU_ADD;
    repeat (10) @(negedge clk);
    bus.Valid = 1'b1; bus.ALU_Control = ALU_MULT; bus.A = 32'd3; bus.B = 32'd4;
    #1;
    check_eq("stall_asserted", 64'(bus.Stall), 64'd1);
    bad = 0;
    for (int i = 0; i < 100 && bus.Busy; i++) begin
      if (bus.Stall !== 1'b1) bad++;
      @(negedge clk);
    end
    check_eq("stall_held", 64'(bad), 64'd0);
    check_eq("stall_release", 64'(bus.Stall), 64'd0);
    check_eq("b2b_done", 64'(bus.Done), 64'd1);
    check_eq("b2b_div_lo", 64'(bus.LO), 64'd14);
    check_eq("b2b_div_hi", 64'(bus.HI), 64'd2);
    @(negedge clk);
    check_eq("b2b_accept_busy", 64'(bus.Busy), 64'd1);
    bus.Valid = 1'b0; bus.ALU_Control = ALU_ADD;
    cyc = 0;
    for (int i = 0; i < 100 && bus.Busy; i++) begin
      cyc++;
      @(negedge clk);
    end
    check_eq("b2b_mul_cycles", 64'(cyc), 64'd33);
    check_eq("b2b_mul_lo", 64'(bus.LO), 64'd12);

    // Reset in the middle of an iteration sequence
    bus.Valid = 1'b1; bus.ALU_Control = ALU_MULT; bus.A = 32'h1234_5678; bus.B = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.Valid = 1'b0; bus.ALU_Control = ALU_ADD;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", 64'(bus.Busy), 64'd0);
    check_eq("abort_hi", 64'(bus.HI), 64'd0);
    check_eq("abort_lo", 64'(bus.LO), 64'd0);
    check_eq("abort_done", 64'(bus.Done), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("abort_no_late_done", 64'(bus.Done), 64'd0);

    // Ignored requests
    bus.Valid = 1'b1; bus.ALU_Control = ALU_SUB;
    #1;
    check_eq("other_code_stall", 64'(bus.Stall), 64'd0);
    @(negedge clk);
    check_eq("other_code_busy", 64'(bus.Busy), 64'd0);
    bus.Valid = 1'b0; bus.ALU_Control = ALU_MULT;
    @(negedge clk);
    check_eq("bubble_busy", 64'(bus.Busy), 64'd0);
    check_eq("bubble_stall", 64'(bus.Stall), 64'd0);
    bus.ALU_Control = ALU_ADD;

    // Full signed product against a 64-bit reference
    ref_prod = $signed({{32{1'b0}}, 32'h1234_5678}) * $signed({{32{1'b1}}, 32'h9ABC_DEF0});
    run_op(ALU_MULT, 32'h1234_5678, 32'h9ABC_DEF0, cyc);
    check_eq("big_mul_cycles", 64'(cyc), 64'd33);
    check_eq("big_mul_prod", {bus.HI, bus.LO}, ref_prod);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative signed multiply/divide unit in the EX stage, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU_Control code together with the ID/EX operands.
- For the mult and div codes it runs a 32-iteration shift-add or restoring-divide sequence, then writes the HI/LO registers.
- While busy, it stalls any further mult/div request from the pipeline.

Parameters:
- WIDTH, 32, operand width; HI/LO width; iteration count.

Ports:
- Clk  input  1  pipeline clock, rising edge
- Reset  input  1  synchronous, active-high
- ALU_Control  input  4  code from ALU control decoder (ID/EX)
- Valid  input  1  ID/EX holds a real instruction (0 = bubble)
- A  input  WIDTH  rs operand (dividend / multiplicand)
- B  input  WIDTH  rt operand (divisor / multiplier)
- Stall  output  1  combinational; a new mult/div request arrived while busy, so the pipeline holds
- Busy  output  1  registered; an operation is in progress
- Done  output  1  registered one-cycle pulse when HI/LO have just been updated
- DivByZero  output  1  registered; the last completed div had B==0; valid with Done, held until the next accept
- HI  output  WIDTH  product[63:32] or remainder
- LO  output  WIDTH  product[31:0] or quotient

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: Busy=0, Done=0, DivByZero=0, HI=0, LO=0, FSM=IDLE, counter=0.
- Reset mid-operation aborts the operation and forces the reset values at that edge.
- Accept: request = Valid & (ALU_Control==ALU_MULT 4'b0101 | ALU_Control==ALU_DIV 4'b1011).
  - A request is accepted on an edge where FSM==IDLE.
  - Any other code, or Valid=0, is ignored.
- Stall = request & Busy. The request is not accepted; upstream holds it until Busy falls and the request is accepted at the next IDLE edge.
- Capture at accept:
  - Latch sign bits sA=A[31] and sB=B[31].
  - Latch magnitudes |A| and |B|; 32'h80000000 has magnitude 2^31, held unsigned.
  - Clear counter.
  - Clear DivByZero unless this is a div with B==0.
- FSM states:
  - IDLE -> MUL on accepted mult.
  - IDLE -> DIV on accepted div with B!=0.
  - IDLE -> FIX on accepted div with B==0.
  - MUL/DIV: one iteration per cycle; after the 32nd iteration (counter==31) -> FIX.
  - FIX: sign correction, write HI/LO -> IDLE.
- MUL iteration: 64-bit accumulator shift-add on the unsigned magnitudes.
  - FIX negates the 64-bit product if sA^sB.
  - {HI,LO} = signed product.
- DIV iteration: restoring, one quotient bit per cycle on the magnitudes.
  - FIX applies quotient sign sA^sB and remainder sign sA.
  - LO = quotient; HI = remainder.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 (wraps) and HI=0.
- Divide by zero: LO=32'hFFFFFFFF, HI=A (unmodified), DivByZero=1.
- Timing, accept at edge 0:
  - mult / div(B!=0): iterations at edges 1..32, FIX at edge 33. HI/LO update at edge 33. Busy=1 from after edge 0 to after edge 33 (33 cycles). Done=1 for the cycle following edge 33.
  - div by zero: FIX at edge 1, Busy for 1 cycle, Done after edge 1.
- HI/LO are unchanged during an operation. Old values stay readable until FIX.
- Back-to-back: a request may be accepted in the same cycle that Done is high, since FSM is IDLE then.

Decomposition:
- Shared package holds:
  - ALU_MULT=4'b0101 and ALU_DIV=4'b1011, alongside the other ALU control code constants.
  - FSM state encoding: IDLE, MUL, DIV, FIX.
  - ITER_LAST=31.
- One natural sub-module: muldiv_datapath. It holds the magnitude/accumulator registers, one-step shift-add and restore logic, and sign fix.
- ex_muldiv_unit keeps the FSM, counter, accept/stall logic and HI/LO registers.

Test Plan:
- Reset, then mult A=7, B=-3 -> Busy for 33 cycles, Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB, DivByZero=0.
- div A=-7, B=2 -> after 33 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Separately, div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- div A=5, B=0 -> Busy 1 cycle, Done next cycle, LO=0xFFFFFFFF, HI=5, DivByZero=1. A following mult then clears DivByZero.
- Second mult requested 10 cycles into a div -> Stall=1 until Busy falls. The second op is then accepted, and the first result is visible (Done) in the same cycle.
- Reset asserted at iteration 15 of mult 0x12345678 x 0x9ABCDEF0 -> next cycle Busy=0, HI=LO=0, no Done. A non-muldiv code, or Valid=0 with the mult code, -> no accept and no Stall.
- Mult 0x12345678 x 0x9ABCDEF0 to completion -> {HI,LO} equals the 64-bit signed product computed by the reference model.
